// File: rtl/raptor64_bcd_addsub_seq.sv
// -----------------------------------------------------------------------------
// raptor64_bcd_addsub_seq
//   Sequential packed-BCD add/subtract unit. Processes DPC decimal digits per
//   clock, least-significant group first, with carry/borrow in and out,
//   invalid-digit flagging and a start/done handshake so the execute stage can
//   stall on it.
//
// Ports
//   clk_i   clock
//   rst_i   synchronous active-high reset
//   ld_i    start request, accepted only while idle
//   op_i    0 = add, 1 = subtract (a - b)
//   ci_i    carry in (add) / borrow in (subtract)
//   a_i     operand A, packed BCD, digit 0 in [3:0]
//   b_i     operand B, packed BCD
//   o       result, packed BCD (partially updated while busy)
//   co_o    final carry out / borrow out
//   err_o   some latched operand digit was > 9
//   busy_o  operation in progress
//   done_o  one-cycle completion pulse
// -----------------------------------------------------------------------------
module raptor64_bcd_addsub_seq #(
   parameter int unsigned WID = 64,
   parameter int unsigned DPC = 2
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           ld_i,
   input  logic           op_i,
   input  logic           ci_i,
   input  logic [WID-1:0] a_i,
   input  logic [WID-1:0] b_i,
   output logic [WID-1:0] o,
   output logic           co_o,
   output logic           err_o,
   output logic           busy_o,
   output logic           done_o
);

   localparam int unsigned GW = 4 * DPC;          // bits per digit group
   localparam int unsigned N  = WID / GW;         // number of groups
   localparam int unsigned CW = $clog2(N + 1);    // group counter width
   localparam logic [CW-1:0] LastG = CW'(N - 1);

   typedef enum logic {StIdle, StRun} state_e;

   state_e         r_state, w_state_nx;
   logic [WID-1:0] r_a, w_a_nx;
   logic [WID-1:0] r_b, w_b_nx;
   logic [WID-1:0] r_o, w_o_nx;
   logic [CW-1:0]  r_g, w_g_nx;
   logic           r_op, w_op_nx;
   logic           r_c, w_c_nx;
   logic           r_co, w_co_nx;
   logic           r_err, w_err_nx;
   logic           r_done, w_done_nx;

   logic [GW-1:0]  w_grp;
   logic           w_grp_c;
   logic           w_bad;

   // Digit-serial ripple through one group. r_a/r_b are shifted down each
   // cycle, so the current group always sits in the low GW bits.
   always_comb begin : grp_chain
      logic       c;
      logic [3:0] da, db;
      logic [4:0] s;
      logic [5:0] d;
      c     = r_c;
      da    = '0;
      db    = '0;
      s     = '0;
      d     = '0;
      w_grp = '0;
      for (int k = 0; k < DPC; k++) begin
         da = r_a[4*k +: 4];
         db = r_b[4*k +: 4];
         if (!r_op) begin
            s = {1'b0, da} + {1'b0, db} + {4'b0, c};
            if (s > 5'd9) begin
               w_grp[4*k +: 4] = s[3:0] + 4'd6;
               c = 1'b1;
            end else begin
               w_grp[4*k +: 4] = s[3:0];
               c = 1'b0;
            end
         end else begin
            // 6-bit two's complement covers -16..15 for raw 4-bit digits
            d = {2'b0, da} - {2'b0, db} - {5'b0, c};
            if (d[5]) begin
               w_grp[4*k +: 4] = d[3:0] + 4'd10;
               c = 1'b1;
            end else begin
               w_grp[4*k +: 4] = d[3:0];
               c = 1'b0;
            end
         end
      end
      w_grp_c = c;
   end

   // Invalid-digit scan of the incoming operands, latched at load.
   always_comb begin
      w_bad = 1'b0;
      for (int k = 0; k < WID / 4; k++) begin
         if (a_i[4*k +: 4] > 4'd9 || b_i[4*k +: 4] > 4'd9) begin
            w_bad = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_a_nx     = r_a;
      w_b_nx     = r_b;
      w_o_nx     = r_o;
      w_g_nx     = r_g;
      w_op_nx    = r_op;
      w_c_nx     = r_c;
      w_co_nx    = r_co;
      w_err_nx   = r_err;
      w_done_nx  = 1'b0;
      case (r_state)
         StIdle: begin
            if (ld_i) begin
               w_state_nx = StRun;
               w_a_nx     = a_i;
               w_b_nx     = b_i;
               w_op_nx    = op_i;
               w_c_nx     = ci_i;
               w_g_nx     = '0;
               w_err_nx   = w_bad;
            end
         end
         StRun: begin
            w_a_nx = r_a >> GW;
            w_b_nx = r_b >> GW;
            for (int k = 0; k < N; k++) begin
               if (r_g == CW'(k)) begin
                  w_o_nx[k*GW +: GW] = w_grp;
               end
            end
            w_c_nx = w_grp_c;
            w_g_nx = r_g + CW'(1);
            if (r_g == LastG) begin
               w_state_nx = StIdle;
               w_done_nx  = 1'b1;
               w_co_nx    = w_grp_c;
            end
         end
         default: w_state_nx = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= StIdle;
         r_a     <= '0;
         r_b     <= '0;
         r_o     <= '0;
         r_g     <= '0;
         r_op    <= 1'b0;
         r_c     <= 1'b0;
         r_co    <= 1'b0;
         r_err   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_a     <= w_a_nx;
         r_b     <= w_b_nx;
         r_o     <= w_o_nx;
         r_g     <= w_g_nx;
         r_op    <= w_op_nx;
         r_c     <= w_c_nx;
         r_co    <= w_co_nx;
         r_err   <= w_err_nx;
         r_done  <= w_done_nx;
      end
   end

   assign o      = r_o;
   assign co_o   = r_co;
   assign err_o  = r_err;
   assign busy_o = (r_state == StRun);
   assign done_o = r_done;

endmodule

// File: tb/tb_raptor64_bcd_addsub_seq.sv
// -----------------------------------------------------------------------------
// tb_raptor64_bcd_addsub_seq
//   Self-checking bench. Three instances (DPC = 2, 1, 16) share operand inputs
//   and have private ld/rst. Expected results come from a decimal-integer
//   model of the packed BCD operands.
// -----------------------------------------------------------------------------
module tb_raptor64_bcd_addsub_seq;

   localparam logic [63:0] All9 = 64'h9999_9999_9999_9999;
   localparam longint unsigned Mod = 64'd10000000000000000;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  rst;
   logic [2:0]  ld;
   logic        op, ci;
   logic [63:0] a, b;

   logic [63:0] o0, o1, o2;
   logic        co0, co1, co2, er0, er1, er2, bz0, bz1, bz2, dn0, dn1, dn2;

   int          sel;
   logic [63:0] c_o;
   logic        c_co, c_err, c_busy, c_done;

   int n_cmp = 0;
   int n_bad = 0;

   raptor64_bcd_addsub_seq #(.WID(64), .DPC(2)) u_dut2 (
      .clk_i(clk), .rst_i(rst[0]), .ld_i(ld[0]), .op_i(op), .ci_i(ci), .a_i(a), .b_i(b),
      .o(o0), .co_o(co0), .err_o(er0), .busy_o(bz0), .done_o(dn0)
   );
   raptor64_bcd_addsub_seq #(.WID(64), .DPC(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst[1]), .ld_i(ld[1]), .op_i(op), .ci_i(ci), .a_i(a), .b_i(b),
      .o(o1), .co_o(co1), .err_o(er1), .busy_o(bz1), .done_o(dn1)
   );
   raptor64_bcd_addsub_seq #(.WID(64), .DPC(16)) u_dut16 (
      .clk_i(clk), .rst_i(rst[2]), .ld_i(ld[2]), .op_i(op), .ci_i(ci), .a_i(a), .b_i(b),
      .o(o2), .co_o(co2), .err_o(er2), .busy_o(bz2), .done_o(dn2)
   );

   always_comb begin
      c_o = o0; c_co = co0; c_err = er0; c_busy = bz0; c_done = dn0;
      if (sel == 1) begin
         c_o = o1; c_co = co1; c_err = er1; c_busy = bz1; c_done = dn1;
      end else if (sel == 2) begin
         c_o = o2; c_co = co2; c_err = er2; c_busy = bz2; c_done = dn2;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s (dut %0d): got %h expected %h", tag, sel, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int lat_of(input int s);
      return (s == 0) ? 8 : (s == 1) ? 16 : 1;
   endfunction

   // ---------------- reference model ----------------
   function automatic longint unsigned bcd2int(input logic [63:0] v);
      longint unsigned r = 0;
      for (int i = 15; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [63:0] int2bcd(input longint unsigned v);
      logic [63:0] r = '0;
      for (int i = 0; i < 16; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic has_bad(input logic [63:0] x, input logic [63:0] y);
      logic bad = 1'b0;
      for (int i = 0; i < 16; i++) if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad = 1'b1;
      return bad;
   endfunction

   task automatic ref_calc(input logic [63:0] av, input logic [63:0] bv, input logic opv,
                           input logic civ, output logic [63:0] r, output logic c);
      longint unsigned x = bcd2int(av);
      longint unsigned y = bcd2int(bv);
      longint unsigned s;
      if (!opv) begin
         s = x + y + longint'(civ);
         c = (s >= Mod);
         r = int2bcd(c ? s - Mod : s);
      end else if (x >= y + longint'(civ)) begin
         c = 1'b0;
         r = int2bcd(x - y - longint'(civ));
      end else begin
         c = 1'b1;
         r = int2bcd(x + Mod - y - longint'(civ));
      end
   endtask

   function automatic logic [63:0] rand_bcd();
      logic [63:0] r = '0;
      for (int i = 0; i < 16; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
      return r;
   endfunction

   // ---------------- stimulus tasks ----------------
   task automatic load(input int s, input logic [63:0] av, input logic [63:0] bv,
                       input logic opv, input logic civ);
      sel = s; a = av; b = bv; op = opv; ci = civ;
      ld[s] = 1'b1;
      step();
      ld[s] = 1'b0;
   endtask

   // Returns in the cycle where done_o is visible.
   task automatic run_op(input int s, input logic [63:0] av, input logic [63:0] bv,
                         input logic opv, input logic civ, input bit chk_res,
                         input logic [63:0] er, input logic ec);
      int n = 0;
      load(s, av, bv, opv, civ);
      chk("err_at_load", 64'(c_err), 64'(has_bad(av, bv)));
      chk("busy_at_load", 64'(c_busy), 64'd1);
      while (c_done !== 1'b1 && n < 64) begin
         step();
         n++;
      end
      chk("latency", 64'(n), 64'(lat_of(s)));
      chk("busy_at_done", 64'(c_busy), 64'd0);
      if (chk_res) begin
         chk("result", c_o, er);
         chk("carry", 64'(c_co), 64'(ec));
      end
   endtask

   task automatic rst_mid(input int s, input int k);
      int cnt = 0;
      load(s, 64'h0000_0000_0000_56AB, 64'h0000_0000_0000_1234, 1'b0, 1'b1);
      chk("rst_busy_before", 64'(c_busy), 64'd1);
      chk("rst_err_before", 64'(c_err), 64'd1);
      repeat (k) step();
      rst[s] = 1'b1;
      step();
      chk("rst_o", c_o, 64'd0);
      chk("rst_co", 64'(c_co), 64'd0);
      chk("rst_err", 64'(c_err), 64'd0);
      chk("rst_busy", 64'(c_busy), 64'd0);
      chk("rst_done", 64'(c_done), 64'd0);
      rst[s] = 1'b0;
      repeat (2 * lat_of(s) + 4) begin
         step();
         if (c_done) cnt++;
      end
      chk("rst_no_done", 64'(cnt), 64'd0);
   endtask

   task automatic rand_ops(input int s, input int cnt);
      logic [63:0] av, bv, er;
      logic        opv, civ, ec;
      bit          bad;
      for (int i = 0; i < cnt; i++) begin
         av  = rand_bcd();
         bv  = rand_bcd();
         opv = 1'($urandom_range(0, 1));
         civ = 1'($urandom_range(0, 1));
         bad = ($urandom_range(0, 7) == 0);
         if (bad) av[4*$urandom_range(0, 15) +: 4] = 4'($urandom_range(10, 15));
         ref_calc(av, bv, opv, civ, er, ec);
         run_op(s, av, bv, opv, civ, !bad, er, ec);
         if ($urandom_range(0, 1) == 1) step();
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cnt, first;
      rst = '1; ld = '0; a = '0; b = '0; op = 1'b0; ci = 1'b0; sel = 0;
      repeat (2) step();
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #0;
         chk("reset_o", c_o, 64'd0);
         chk("reset_co", 64'(c_co), 64'd0);
         chk("reset_err", 64'(c_err), 64'd0);
         chk("reset_busy", 64'(c_busy), 64'd0);
         chk("reset_done", 64'(c_done), 64'd0);
      end
      rst = '0;
      step();

      // Directed cases, DPC = 2
      run_op(0, 64'h0999, 64'h0001, 1'b0, 1'b0, 1, 64'h1000, 1'b0);
      step();
      chk("done_pulse_width", 64'(c_done), 64'd0);
      chk("hold_result", c_o, 64'h1000);
      run_op(0, All9, 64'h1, 1'b0, 1'b0, 1, 64'h0, 1'b1);
      run_op(0, All9, 64'h0, 1'b0, 1'b1, 1, 64'h0, 1'b1);
      run_op(0, 64'h0100, 64'h0001, 1'b1, 1'b0, 1, 64'h0099, 1'b0);
      run_op(0, 64'h0, 64'h1, 1'b1, 1'b0, 1, All9, 1'b1);

      // Invalid digit, then a valid op clears err_o
      run_op(0, 64'h000A, 64'h0, 1'b0, 1'b0, 0, 64'h0, 1'b0);
      chk("err_held", 64'(c_err), 64'd1);
      run_op(0, 64'h0012, 64'h0034, 1'b0, 1'b0, 1, 64'h0046, 1'b0);
      chk("err_cleared", 64'(c_err), 64'd0);

      // ld_i during the done_o cycle is accepted
      run_op(0, 64'h5, 64'h3, 1'b0, 1'b0, 1, 64'h8, 1'b0);
      run_op(0, 64'h20, 64'h22, 1'b0, 1'b0, 1, 64'h42, 1'b0);
      step();

      // ld_i pulses during RUN are ignored
      load(0, 64'h1234, 64'h0111, 1'b0, 1'b0);
      a = 64'h9999; b = 64'h9999;
      cnt = 0; first = 0;
      for (int n = 1; n <= 20; n++) begin
         ld[0] = (n == 3 || n == 5);
         step();
         if (c_done) begin
            cnt++;
            if (first == 0) first = n;
         end
      end
      ld[0] = 1'b0;
      chk("hs_done_count", 64'(cnt), 64'd1);
      chk("hs_done_edge", 64'(first), 64'd8);
      chk("hs_result", c_o, 64'h1345);

      rst_mid(0, 3);
      rand_ops(0, 40);

      // DPC = 1
      run_op(1, 64'h0999, 64'h0001, 1'b0, 1'b0, 1, 64'h1000, 1'b0);
      run_op(1, 64'h0, 64'h1, 1'b1, 1'b0, 1, All9, 1'b1);
      rst_mid(1, 3);
      rand_ops(1, 10);

      // DPC = 16
      run_op(2, All9, 64'h1, 1'b0, 1'b0, 1, 64'h0, 1'b1);
      run_op(2, 64'h0100, 64'h0001, 1'b1, 1'b0, 1, 64'h0099, 1'b0);
      rst_mid(2, 0);
      rand_ops(2, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
